// File: rtl/fc_dec_pkg.sv
// Shared types and constants for the decoder-side FC BRAM controller.
// Lane positions match the packed formats used by the encoder controller.
package fc_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_DIM_INPUT  = 8;
  localparam int DEF_DIM_OUTPUT = 96;
  localparam int LOAD_WORDS     = DEF_DIM_INPUT / 2;
  localparam int STORE_WORDS    = DEF_DIM_OUTPUT / 2;

  // Latent word {8'h00, b, 8'h00, a}; result word {even, odd}.
  localparam int LAT_A_LSB    = 0;
  localparam int LAT_B_LSB    = 16;
  localparam int RES_EVEN_LSB = 16;
  localparam int RES_ODD_LSB  = 0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] pack_pair(input logic [15:0] even, input logic [15:0] odd);
    logic [31:0] w;
    w = '0;
    w[RES_EVEN_LSB +: 16] = even;
    w[RES_ODD_LSB +: 16]  = odd;
    return w;
  endfunction

endpackage

// File: rtl/fc_dec_loader.sv
// Latent read path: load counter, read address generation and the serial
// latent stream towards the decoder engine.
module fc_dec_loader
  import fc_dec_pkg::*;
#(
  parameter int DIM_INPUT = DEF_DIM_INPUT,
  parameter int INPUT_W   = 8,
  parameter int ADDR_SW   = 12,
  parameter int SW        = 4,
  parameter logic [ADDR_SW-1:0] LOAD_BASE = 'hD00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic [SW-1:0]      sample,
  input  logic [31:0]        dec_dout,
  output logic [ADDR_SW-1:0] rd_addr,
  output logic               rd_last,
  output logic               dec_in_vld,
  output logic [INPUT_W-1:0] dec_in_dat
);

  localparam int LCW     = cnt_width(DIM_INPUT);
  localparam int N_WORDS = DIM_INPUT / 2;

  logic [LCW-1:0] lc_reg;
  logic           lane_reg;
  logic           vld_reg;
  logic           unused_dout;

  assign rd_last = (lc_reg == LCW'(DIM_INPUT - 1));
  assign rd_addr = LOAD_BASE + ADDR_SW'(sample) * ADDR_SW'(N_WORDS) + ADDR_SW'(lc_reg >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      lc_reg   <= '0;
      lane_reg <= 1'b0;
      vld_reg  <= 1'b0;
    end else begin
      vld_reg  <= active;
      lane_reg <= lc_reg[0];
      if (active && !rd_last)
        lc_reg <= lc_reg + 1'b1;
      else
        lc_reg <= '0;
    end
  end

  // BRAM data arrives one cycle after the read, so the lane select is the delayed lc.
  assign dec_in_vld = vld_reg;
  assign dec_in_dat = !vld_reg ? '0 :
                      lane_reg ? dec_dout[LAT_B_LSB +: INPUT_W] : dec_dout[LAT_A_LSB +: INPUT_W];

  assign unused_dout = ^dec_dout;

endmodule

// File: rtl/fc_dec_ctrl.sv
// Decoder FC BRAM controller: streams latent codes into the engine and writes
// the reconstructed halfwords back two per word, BATCH_NUM samples per start.
module fc_dec_ctrl
  import fc_dec_pkg::*;
#(
  parameter int DIM_INPUT  = DEF_DIM_INPUT,
  parameter int DIM_OUTPUT = DEF_DIM_OUTPUT,
  parameter int INPUT_W    = 8,
  parameter int OUTPUT_W   = 16,
  parameter int ADDR_SW    = 12,
  parameter int BATCH_NUM  = 10,
  parameter logic [ADDR_SW-1:0] LOAD_BASE  = 'hD00,
  parameter logic [ADDR_SW-1:0] STORE_BASE = 'h000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           dec_in_vld,
  output logic [INPUT_W-1:0]             dec_in_dat,
  input  logic                           dec_out_vld,
  input  logic [OUTPUT_W*DIM_OUTPUT-1:0] dec_out_dat,
  output logic [ADDR_SW-1:0]             dec_addr,
  output logic                           dec_en,
  output logic                           dec_we,
  output logic [31:0]                    dec_din,
  input  logic [31:0]                    dec_dout
);

  localparam int SW      = cnt_width(BATCH_NUM);
  localparam int N_STORE = DIM_OUTPUT / 2;
  localparam int JW      = cnt_width(N_STORE);

  state_t                         state_reg;
  logic [SW-1:0]                  s_reg;
  logic [JW-1:0]                  j_reg;
  logic [OUTPUT_W*DIM_OUTPUT-1:0] res_reg;
  logic                           busy_reg;
  logic                           done_reg;

  logic                   load_active;
  logic                   store_active;
  logic                   rd_last;
  logic                   st_last;
  logic                   s_last;
  logic [ADDR_SW-1:0]     rd_addr;
  logic [ADDR_SW-1:0]     st_addr;
  logic [N_STORE-1:0][31:0] pair_words;

  assign load_active  = (state_reg == ST_LOAD);
  assign store_active = (state_reg == ST_STORE);
  assign st_last      = (j_reg == JW'(N_STORE - 1));
  assign s_last       = (s_reg == SW'(BATCH_NUM - 1));
  assign st_addr      = STORE_BASE + ADDR_SW'(s_reg) * ADDR_SW'(N_STORE) + ADDR_SW'(j_reg);

  fc_dec_loader #(
    .DIM_INPUT (DIM_INPUT),
    .INPUT_W   (INPUT_W),
    .ADDR_SW   (ADDR_SW),
    .SW        (SW),
    .LOAD_BASE (LOAD_BASE)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .active     (load_active),
    .sample     (s_reg),
    .dec_dout   (dec_dout),
    .rd_addr    (rd_addr),
    .rd_last    (rd_last),
    .dec_in_vld (dec_in_vld),
    .dec_in_dat (dec_in_dat)
  );

  for (genvar gi = 0; gi < N_STORE; gi++) begin : g_pack
    assign pair_words[gi] = pack_pair(16'(res_reg[(2*gi)*OUTPUT_W +: OUTPUT_W]),
                                      16'(res_reg[(2*gi+1)*OUTPUT_W +: OUTPUT_W]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      j_reg     <= '0;
      res_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_LOAD;
            s_reg     <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (rd_last)
            state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dec_out_vld) begin
            res_reg   <= dec_out_dat;
            j_reg     <= '0;
            state_reg <= ST_STORE;
          end
        end
        ST_STORE: begin
          if (st_last) begin
            j_reg <= '0;
            if (s_last) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              s_reg     <= s_reg + 1'b1;
              state_reg <= ST_LOAD;
            end
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign dec_en   = load_active | store_active;
  assign dec_we   = store_active;
  assign dec_addr = load_active ? rd_addr : (store_active ? st_addr : '0);
  assign dec_din  = store_active ? pair_words[j_reg] : '0;

endmodule

// File: tb/tb_fc_dec_ctrl.sv
// Directed bench for fc_dec_ctrl with a behavioural BRAM and a scripted engine.
module tb_fc_dec_ctrl;

  localparam int DI = 8;
  localparam int DO = 96;
  localparam int NB = 10;
  localparam int SW_WORDS = DO / 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic           dec_in_vld;
  logic [7:0]     dec_in_dat;
  logic           dec_out_vld;
  logic [DO*16-1:0] dec_out_dat;
  logic [11:0]    dec_addr;
  logic           dec_en;
  logic           dec_we;
  logic [31:0]    dec_din;
  logic [31:0]    dec_dout;

  logic [31:0] mem [4096];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_din;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fc_dec_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .dec_in_vld  (dec_in_vld),
    .dec_in_dat  (dec_in_dat),
    .dec_out_vld (dec_out_vld),
    .dec_out_dat (dec_out_dat),
    .dec_addr    (dec_addr),
    .dec_en      (dec_en),
    .dec_we      (dec_we),
    .dec_din     (dec_din),
    .dec_dout    (dec_dout)
  );

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_din;
    else if (dec_en) begin
      if (dec_we)
        mem[dec_addr] <= dec_din;
      dec_dout <= mem[dec_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] elem(input int s, input int i);
    return 16'(32'h100 + s * 32'h100 + i);
  endfunction

  function automatic logic [7:0] latent(input int s, input int lc);
    return 8'(s * 16 + lc + 1);
  endfunction

  function automatic logic [DO*16-1:0] mk_res(input int s);
    logic [DO*16-1:0] v;
    for (int i = 0; i < DO; i++) v[i*16 +: 16] = elem(s, i);
    return v;
  endfunction

  // Entered in the first LOAD cycle of sample s; leaves in the cycle after its last store.
  task automatic do_sample(input int s, input int delay, input bit disturb, input int abort_j);
    for (int lc = 0; lc < DI; lc++) begin
      check("ld_en", dec_en, 1);
      check("ld_we", dec_we, 0);
      check("ld_busy", busy, 1);
      check("ld_addr", dec_addr, 32'(12'hD00 + s * 4 + lc / 2));
      check("ld_vld", dec_in_vld, (lc > 0));
      if (lc > 0) check("ld_dat", dec_in_dat, latent(s, lc - 1));
      start       = disturb && (lc == 3);
      dec_out_vld = disturb && (lc == 5);
      dec_out_dat = ~mk_res(s);
      tick();
    end
    start = 0;
    dec_out_vld = 0;
    check("ld_vld_last", dec_in_vld, 1);
    check("ld_dat_last", dec_in_dat, latent(s, DI - 1));
    for (int d = 0; d < delay; d++) begin
      check("wt_en", dec_en, 0);
      check("wt_busy", busy, 1);
      start = disturb && (d == 0);
      tick();
    end
    start = 0;
    check("wt_en_vld", dec_en, 0);
    dec_out_vld = 1;
    dec_out_dat = mk_res(s);
    tick();
    dec_out_vld = 0;
    dec_out_dat = ~mk_res(s);
    for (int j = 0; j < SW_WORDS; j++) begin
      if (j == abort_j) begin
        rst = 1;
        tick();
        rst = 0;
        check("rst_en", dec_en, 0);
        check("rst_we", dec_we, 0);
        check("rst_addr", dec_addr, 0);
        check("rst_din", dec_din, 0);
        check("rst_vld", dec_in_vld, 0);
        check("rst_dat", dec_in_dat, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        return;
      end
      check("st_en", dec_en, 1);
      check("st_we", dec_we, 1);
      check("st_addr", dec_addr, 32'(s * SW_WORDS + j));
      check("st_din", dec_din, {elem(s, 2 * j), elem(s, 2 * j + 1)});
      start       = disturb && (j == 10);
      dec_out_vld = disturb && (j == 20);
      tick();
    end
    start = 0;
    dec_out_vld = 0;
  endtask

  task automatic run_batch(input int d0, input int dstep);
    check("idle_busy", busy, 0);
    start = 1;
    tick();
    start = 0;
    for (int s = 0; s < NB; s++) begin
      do_sample(s, d0 + dstep * s, (s == 1), -1);
      $display("sample %0d stored, engine delay %0d", s, d0 + dstep * s);
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_en", dec_en, 0);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    tick();
    check("post_done2", done, 0);
    check("post_en", dec_en, 0);
  endtask

  task automatic check_mem();
    for (int a = 0; a < NB * SW_WORDS; a++)
      check("mem", mem[a], {elem(a / SW_WORDS, 2 * (a % SW_WORDS)), elem(a / SW_WORDS, 2 * (a % SW_WORDS) + 1)});
  endtask

  initial begin
    rst = 1;
    start = 0;
    dec_out_vld = 0;
    dec_out_dat = '0;
    pre_we = 0;
    pre_addr = '0;
    pre_din = '0;
    tick();
    tick();
    for (int s = 0; s < NB; s++) begin
      for (int k = 0; k < DI / 2; k++) begin
        pre_we   = 1;
        pre_addr = 12'(12'hD00 + s * 4 + k);
        pre_din  = {8'h00, latent(s, 2 * k + 1), 8'h00, latent(s, 2 * k)};
        tick();
      end
    end
    pre_we = 0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_en", dec_en, 0);
    check("reset_we", dec_we, 0);
    check("reset_addr", dec_addr, 0);
    check("reset_din", dec_din, 0);
    check("reset_vld", dec_in_vld, 0);
    check("reset_dat", dec_in_dat, 0);
    rst = 0;
    tick();

    // Full batch, engine delay 0..45.
    run_batch(0, 5);
    check_mem();
    $display("batch 1 complete");

    // Abort in the STORE phase of sample 3, then restart from sample 0.
    start = 1;
    tick();
    start = 0;
    for (int s = 0; s < 3; s++) do_sample(s, 2, 1'b0, -1);
    do_sample(3, 2, 1'b0, 20);
    tick();
    check("abort_idle_en", dec_en, 0);
    check("abort_idle_busy", busy, 0);
    $display("abort at sample 3 complete");

    for (int a = 0; a < NB * SW_WORDS; a++) begin
      pre_we   = 1;
      pre_addr = 12'(a);
      pre_din  = 32'hDEADBEEF;
      tick();
    end
    pre_we = 0;

    // Full batch, engine delay 50..5.
    run_batch(50, -5);
    check_mem();
    $display("batch 2 complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
